// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB stage: writeback source select and load funct3 codes.
package mem_wb_stage_pkg;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load extraction from an aligned memory word, with misalignment / bad-funct3 detection.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = 32'd0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: data = {24'd0, byte_sel};
            F3_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                data       = {16'd0, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (offset != 2'd0);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline slot: writeback mux, load alignment, fault flag and retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_rdata,
    input  logic [31:0] in_pc_plus4,
    input  logic [31:0] in_imm,
    output logic [4:0]  Wt_addr,
    output logic [31:0] Wt_data,
    output logic        L_S,
    output logic        wb_valid,
    output logic        misaligned_load,
    output logic [63:0] instret
);

    logic [31:0] load_data;
    logic        load_fault;
    logic        misaligned;
    logic [31:0] wb_data;

    logic [4:0]  wt_addr_d,    wt_addr_q;
    logic [31:0] wt_data_d,    wt_data_q;
    logic        l_s_d,        l_s_q;
    logic        wb_valid_d,   wb_valid_q;
    logic        misaligned_d, misaligned_q;
    logic [63:0] instret_d,    instret_q;

    load_align u_load_align (
        .rdata      (in_mem_rdata),
        .offset     (in_alu_result[1:0]),
        .funct3     (in_funct3),
        .data       (load_data),
        .misaligned (load_fault)
    );

    // Alignment faults only matter when the load path is actually selected.
    assign misaligned = (in_wb_sel == WB_LOAD) && load_fault;

    always_comb begin
        wb_data = in_alu_result;
        case (in_wb_sel)
            WB_ALU:  wb_data = in_alu_result;
            WB_LOAD: wb_data = load_data;
            WB_PC4:  wb_data = in_pc_plus4;
            WB_IMM:  wb_data = in_imm;
            default: wb_data = in_alu_result;
        endcase
    end

    always_comb begin
        wt_addr_d    = wt_addr_q;
        wt_data_d    = wt_data_q;
        l_s_d        = l_s_q;
        wb_valid_d   = wb_valid_q;
        misaligned_d = misaligned_q;
        instret_d    = instret_q;
        if (flush) begin
            wt_addr_d    = 5'd0;
            wt_data_d    = 32'd0;
            l_s_d        = 1'b0;
            wb_valid_d   = 1'b0;
            misaligned_d = 1'b0;
        end else if (!stall) begin
            wt_addr_d    = in_rd;
            wt_data_d    = misaligned ? 32'd0 : wb_data;
            l_s_d        = in_valid && in_reg_write && (in_rd != 5'd0) && !misaligned;
            wb_valid_d   = in_valid;
            misaligned_d = in_valid && misaligned;
            if (in_valid && !misaligned)
                instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_addr_q    <= 5'd0;
            wt_data_q    <= 32'd0;
            l_s_q        <= 1'b0;
            wb_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            wt_addr_q    <= wt_addr_d;
            wt_data_q    <= wt_data_d;
            l_s_q        <= l_s_d;
            wb_valid_q   <= wb_valid_d;
            misaligned_q <= misaligned_d;
            instret_q    <= instret_d;
        end
    end

    assign Wt_addr         = wt_addr_q;
    assign Wt_data         = wt_data_q;
    assign L_S             = l_s_q;
    assign wb_valid        = wb_valid_q;
    assign misaligned_load = misaligned_q;
    assign instret         = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations checked after each edge.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;
    logic        L_S, wb_valid, misaligned_load;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .Wt_addr(Wt_addr), .Wt_data(Wt_data), .L_S(L_S), .wb_valid(wb_valid),
        .misaligned_load(misaligned_load), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [31:0] imm);
        in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel; in_funct3 = f3;
        in_alu_result = alu; in_mem_rdata = rdata; in_pc_plus4 = pc4; in_imm = imm;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] a, input logic [31:0] d,
                              input logic ls, input logic v, input logic m, input logic [63:0] n);
        check({tag, ".addr"}, 64'(Wt_addr), 64'(a));
        check({tag, ".data"}, 64'(Wt_data), 64'(d));
        check({tag, ".L_S"}, 64'(L_S), 64'(ls));
        check({tag, ".valid"}, 64'(wb_valid), 64'(v));
        check({tag, ".mis"}, 64'(misaligned_load), 64'(m));
        check({tag, ".instret"}, instret, n);
    endtask

    initial begin
        // reset overrides stall/flush/valid traffic
        rst = 1'b1; stall = 1'b1; flush = 1'b1;
        drive(1, 1, 5'd9, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        expect_out("reset", 5'd0, 32'h0, 0, 0, 0, 64'd0);

        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 5'd5, 2'b01, 3'b000, 32'h1003, 32'h80FF_1234, 32'h0, 32'h0);
        tick();
        expect_out("lb_sext", 5'd5, 32'hFFFF_FF80, 1, 1, 0, 64'd1);

        drive(1, 1, 5'd6, 2'b01, 3'b101, 32'h2002, 32'hBEEF_0000, 32'h0, 32'h0);
        tick();
        expect_out("lhu_off2", 5'd6, 32'h0000_BEEF, 1, 1, 0, 64'd2);

        drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h3001, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick();
        expect_out("lw_mis", 5'd7, 32'h0, 0, 1, 1, 64'd2);

        drive(1, 1, 5'd8, 2'b01, 3'b001, 32'h4000, 32'h0000_8001, 32'h0, 32'h0);
        tick();
        expect_out("lh_sext", 5'd8, 32'hFFFF_8001, 1, 1, 0, 64'd3);

        drive(1, 1, 5'd10, 2'b01, 3'b100, 32'h5001, 32'h0000_A500, 32'h0, 32'h0);
        tick();
        expect_out("lbu_off1", 5'd10, 32'h0000_00A5, 1, 1, 0, 64'd4);

        drive(1, 1, 5'd11, 2'b01, 3'b001, 32'h5003, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        expect_out("lh_off3_mis", 5'd11, 32'h0, 0, 1, 1, 64'd4);

        drive(1, 1, 5'd0, 2'b10, 3'b000, 32'h0, 32'h0, 32'h104, 32'h0);
        tick();
        expect_out("x0_pc4", 5'd0, 32'h104, 0, 1, 0, 64'd5);

        drive(1, 1, 5'd12, 2'b11, 3'b000, 32'h0, 32'h0, 32'h0, 32'h1234_5000);
        tick();
        expect_out("imm", 5'd12, 32'h1234_5000, 1, 1, 0, 64'd6);

        drive(1, 1, 5'd13, 2'b01, 3'b011, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        tick();
        expect_out("bad_f3_load", 5'd13, 32'h0, 0, 1, 1, 64'd6);

        drive(1, 1, 5'd14, 2'b00, 3'b011, 32'h3, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("bad_f3_alu", 5'd14, 32'h3, 1, 1, 0, 64'd7);

        drive(1, 1, 5'd3, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("alu55", 5'd3, 32'h55, 1, 1, 0, 64'd8);

        stall = 1'b1;
        drive(1, 1, 5'd9, 2'b00, 3'b000, 32'hAA, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("stall1", 5'd3, 32'h55, 1, 1, 0, 64'd8);
        drive(1, 1, 5'd15, 2'b10, 3'b000, 32'h0, 32'h0, 32'h200, 32'h0);
        tick();
        expect_out("stall2", 5'd3, 32'h55, 1, 1, 0, 64'd8);
        tick();
        expect_out("stall3", 5'd3, 32'h55, 1, 1, 0, 64'd8);

        flush = 1'b1;
        tick();
        expect_out("stall_flush", 5'd0, 32'h0, 0, 0, 0, 64'd8);

        stall = 1'b0; flush = 1'b0;
        drive(0, 1, 5'd17, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("invalid", 5'd17, 32'h77, 0, 0, 0, 64'd8);

        drive(0, 1, 5'd18, 2'b01, 3'b010, 32'h2, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("invalid_mis", 5'd18, 32'h0, 0, 0, 0, 64'd8);

        drive(1, 0, 5'd19, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("no_rw", 5'd19, 32'h99, 0, 1, 0, 64'd9);

        rst = 1'b1; stall = 1'b1;
        drive(1, 1, 5'd20, 2'b00, 3'b000, 32'h66, 32'h0, 32'h0, 32'h0);
        tick();
        expect_out("mid_reset", 5'd0, 32'h0, 0, 0, 0, 64'd0);

        rst = 1'b0; stall = 1'b0;
        tick();
        expect_out("after_reset", 5'd20, 32'h66, 1, 1, 0, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
